// File: rtl/axi4_wr_arbiter.sv
// rtl/axi4_wr_arbiter.sv - two-master round-robin arbiter for one AXI4 write slave
module axi4_wr_arbiter #(
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [2*ADDR_WIDTH-1:0] m_AWADDR,
  input  logic [15:0]             m_AWLEN,
  input  logic [5:0]              m_AWSIZE,
  input  logic [3:0]              m_AWBURST,
  input  logic [1:0]              m_AWVALID,
  output logic [1:0]              m_AWREADY,
  input  logic [2*DATA_WIDTH-1:0] m_WDATA,
  input  logic [2*STRB_WIDTH-1:0] m_WSTRB,
  input  logic [1:0]              m_WLAST,
  input  logic [1:0]              m_WVALID,
  output logic [1:0]              m_WREADY,
  output logic [1:0]              m_BRESP,
  output logic [1:0]              m_BVALID,
  input  logic [1:0]              m_BREADY,
  output logic [ADDR_WIDTH-1:0]   s_AWADDR,
  output logic [7:0]              s_AWLEN,
  output logic [2:0]              s_AWSIZE,
  output logic [1:0]              s_AWBURST,
  output logic                    s_AWVALID,
  input  logic                    s_AWREADY,
  output logic [DATA_WIDTH-1:0]   s_WDATA,
  output logic [STRB_WIDTH-1:0]   s_WSTRB,
  output logic                    s_WLAST,
  output logic                    s_WVALID,
  input  logic                    s_WREADY,
  input  logic [1:0]              s_BRESP,
  input  logic                    s_BVALID,
  output logic                    s_BREADY,
  output logic [1:0]              grant,
  output logic                    wlast_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AW   = 2'd1;
  localparam logic [1:0] W    = 2'd2;
  localparam logic [1:0] B    = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       wlast_err_q, wlast_err_d;
  logic       gi;
  logic       last_beat;

  assign gi        = grant_q[1];
  assign last_beat = (beat_cnt_q == len_q);
  assign grant     = grant_q;
  assign wlast_err = wlast_err_q;

  // Payloads are zeroed outside their phase so nothing leaks while idle or in reset.
  always_comb begin
    m_AWREADY = '0;
    m_WREADY  = '0;
    m_BVALID  = '0;
    m_BRESP   = '0;
    s_AWADDR  = '0;
    s_AWLEN   = '0;
    s_AWSIZE  = '0;
    s_AWBURST = '0;
    s_AWVALID = 1'b0;
    s_WDATA   = '0;
    s_WSTRB   = '0;
    s_WLAST   = 1'b0;
    s_WVALID  = 1'b0;
    s_BREADY  = 1'b0;
    case (state_q)
      AW: begin
        s_AWADDR      = gi ? m_AWADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_AWADDR[ADDR_WIDTH-1:0];
        s_AWLEN       = gi ? m_AWLEN[15:8] : m_AWLEN[7:0];
        s_AWSIZE      = gi ? m_AWSIZE[5:3] : m_AWSIZE[2:0];
        s_AWBURST     = gi ? m_AWBURST[3:2] : m_AWBURST[1:0];
        s_AWVALID     = m_AWVALID[gi];
        m_AWREADY[gi] = s_AWREADY;
      end
      W: begin
        s_WDATA      = gi ? m_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : m_WDATA[DATA_WIDTH-1:0];
        s_WSTRB      = gi ? m_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH] : m_WSTRB[STRB_WIDTH-1:0];
        s_WLAST      = m_WLAST[gi];
        s_WVALID     = m_WVALID[gi];
        m_WREADY[gi] = s_WREADY;
      end
      B: begin
        m_BVALID[gi] = s_BVALID;
        m_BRESP      = s_BRESP;
        s_BREADY     = m_BREADY[gi];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_AWVALID) begin
          state_d = AW;
          if (m_AWVALID == 2'b11) grant_d = rr_ptr_q ? 2'b10 : 2'b01;
          else                    grant_d = m_AWVALID;
        end
      end
      AW: begin
        if (m_AWVALID[gi] && s_AWREADY) begin
          len_d      = gi ? m_AWLEN[15:8] : m_AWLEN[7:0];
          beat_cnt_d = 8'd0;
          state_d    = W;
        end
      end
      W: begin
        // The burst ends on the beat count; WLAST is only audited, never trusted.
        if (m_WVALID[gi] && s_WREADY) begin
          beat_cnt_d  = beat_cnt_q + 8'd1;
          wlast_err_d = (m_WLAST[gi] != last_beat);
          if (last_beat) state_d = B;
        end
      end
      B: begin
        if (s_BVALID && m_BREADY[gi]) begin
          state_d  = IDLE;
          grant_d  = 2'b00;
          rr_ptr_d = ~gi;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      rr_ptr_q    <= 1'b0;
      len_q       <= 8'd0;
      beat_cnt_q  <= 8'd0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// tb/tb_axi4_wr_arbiter.sv - randomized scoreboard bench for axi4_wr_arbiter
module tb_axi4_wr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] m_AWADDR;
  logic [15:0] m_AWLEN;
  logic [5:0]  m_AWSIZE;
  logic [3:0]  m_AWBURST;
  logic [1:0]  m_AWVALID, m_AWREADY;
  logic [63:0] m_WDATA;
  logic [7:0]  m_WSTRB;
  logic [1:0]  m_WLAST, m_WVALID, m_WREADY;
  logic [1:0]  m_BRESP, m_BVALID, m_BREADY;
  logic [15:0] s_AWADDR;
  logic [7:0]  s_AWLEN;
  logic [2:0]  s_AWSIZE;
  logic [1:0]  s_AWBURST;
  logic        s_AWVALID, s_AWREADY;
  logic [31:0] s_WDATA;
  logic [3:0]  s_WSTRB;
  logic        s_WLAST, s_WVALID, s_WREADY;
  logic [1:0]  s_BRESP;
  logic        s_BVALID, s_BREADY;
  logic [1:0]  grant;
  logic        wlast_err;

  always #5 ACLK = ~ACLK;

  axi4_wr_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE), .m_AWBURST(m_AWBURST),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE), .s_AWBURST(s_AWBURST),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .grant(grant), .wlast_err(wlast_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master agents: one outstanding burst each.
  logic        pend [2];
  logic        wact [2];
  logic        bact [2];
  logic        badl [2];
  int          beat [2];
  int          len  [2];
  logic [15:0] addr [2];
  int          done [2];

  // Reference model of the arbitration and slave-side transaction.
  logic        busy = 1'b0;
  int          owner = 0;
  int          last = 1;
  logic [1:0]  exp_grant = 2'b00;
  logic        exp_err = 1'b0;
  int          sb_beats = 0;
  int          sb_len = 0;
  logic        sb_pend = 1'b0;
  logic [1:0]  resp_q = 2'b00;
  int          err_pulses = 0;
  int          order [$];
  logic        rnd = 1'b0;
  logic        wtog = 1'b0;
  logic        wtog_ph = 1'b0;

  function automatic logic [31:0] wdat(input int i, input logic [15:0] a, input int b);
    logic [31:0] i32;
    logic [31:0] b32;
    i32 = i;
    b32 = b;
    return {i32[3:0], a[11:0], b32[15:0]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; wact[i] = 0; bact[i] = 0; badl[i] = 0;
      beat[i] = 0; len[i] = 0; addr[i] = '0;
    end
    busy = 0; owner = 0; last = 1; exp_grant = 2'b00; exp_err = 0;
    sb_pend = 0; sb_beats = 0; sb_len = 0; resp_q = 2'b00;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      m_AWVALID[i]       = pend[i];
      m_AWADDR[i*16 +: 16] = addr[i];
      m_AWLEN[i*8 +: 8]  = len[i][7:0];
      m_AWSIZE[i*3 +: 3] = 3'd2;
      m_AWBURST[i*2 +: 2] = 2'd1;
      m_WVALID[i]        = wact[i] && (!rnd || $urandom_range(0, 3) != 0);
      m_WDATA[i*32 +: 32] = wdat(i, addr[i], beat[i]);
      m_WSTRB[i*4 +: 4]  = 4'hf;
      m_WLAST[i]         = badl[i] ? (beat[i] == 0) : (beat[i] == len[i]);
      m_BREADY[i]        = bact[i] && (!rnd || $urandom_range(0, 1) == 1);
    end
    s_AWREADY = !rnd || $urandom_range(0, 1) == 1;
    wtog_ph   = ~wtog_ph;
    s_WREADY  = wtog ? wtog_ph : (!rnd || $urandom_range(0, 2) != 0);
    s_BVALID  = sb_pend && (!rnd || $urandom_range(0, 1) == 1);
    s_BRESP   = resp_q;
  endtask

  task automatic sample();
    logic next_err;
    next_err = 1'b0;
    check_eq("grant", grant, exp_grant);
    check_eq("wlast_err", wlast_err, exp_err);
    if (wlast_err) err_pulses++;
    check_eq("isolation", (m_AWREADY | m_WREADY | m_BVALID) & ~exp_grant, 0);
    for (int i = 0; i < 2; i++) begin
      if (m_AWVALID[i] && m_AWREADY[i]) begin
        check_eq("aw_owner", i, owner);
        check_eq("aw_slave_hs", s_AWVALID && s_AWREADY, 1);
        check_eq("aw_addr", s_AWADDR, addr[i]);
        check_eq("aw_len", s_AWLEN, len[i]);
        pend[i] = 0; wact[i] = 1; beat[i] = 0;
        sb_len = len[i]; sb_beats = 0;
        resp_q = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      end
    end
    if (s_WVALID && s_WREADY) begin
      check_eq("w_in_burst", busy && wact[owner], 1);
      check_eq("w_master_hs", m_WVALID[owner] && m_WREADY[owner], 1);
      check_eq("wdata", s_WDATA, wdat(owner, addr[owner], beat[owner]));
      check_eq("wlast_fwd", s_WLAST, m_WLAST[owner]);
      next_err = (m_WLAST[owner] != (beat[owner] == len[owner]));
      beat[owner]++;
      sb_beats++;
      if (beat[owner] == len[owner] + 1) begin
        wact[owner] = 0; bact[owner] = 1; sb_pend = 1;
      end
    end
    if (s_BVALID && s_BREADY) begin
      check_eq("b_master_hs", m_BVALID[owner] && m_BREADY[owner], 1);
      check_eq("bresp", m_BRESP, resp_q);
      check_eq("beats", sb_beats, sb_len + 1);
      bact[owner] = 0; sb_pend = 0; busy = 0; last = owner;
      done[owner]++;
      order.push_back(owner);
      exp_grant = 2'b00;
    end else if (!busy && (pend[0] || pend[1])) begin
      // Sole requester wins; a tie goes to whoever was not served last.
      owner     = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
      busy      = 1;
      exp_grant = (owner == 0) ? 2'b01 : 2'b10;
    end
    exp_err = next_err;
  endtask

  task automatic step();
    @(negedge ACLK);
    drive();
    #4;
    sample();
  endtask

  task automatic start(input int i, input logic [15:0] a, input int l, input logic bad);
    pend[i] = 1; addr[i] = a; len[i] = l; badl[i] = bad;
  endtask

  task automatic wait_done(input int t0, input int t1, input int maxc, input string tag);
    int n;
    n = 0;
    while ((done[0] < t0 || done[1] < t1) && n < maxc) begin
      step();
      n++;
    end
    check_eq(tag, (done[0] >= t0 && done[1] >= t1), 1);
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #2;
    ARESETn = 0;
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_m_side", {m_AWREADY, m_WREADY, m_BVALID}, 0);
    check_eq("rst_s_side", {s_AWVALID, s_WVALID, s_BREADY, wlast_err}, 0);
    clear_model();
    drive();
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
  endtask

  initial begin
    int n;
    int launched;
    int target;
    done[0] = 0; done[1] = 0;
    clear_model();
    m_AWVALID = 2'b11; m_WVALID = 2'b11; m_BREADY = 2'b11; m_WLAST = 2'b11;
    m_AWADDR = '1; m_AWLEN = '1; m_AWSIZE = '0; m_AWBURST = '0; m_WDATA = '1; m_WSTRB = '1;
    s_AWREADY = 1; s_WREADY = 1; s_BVALID = 1; s_BRESP = 2'b10;
    #1;
    check_eq("init_grant", grant, 0);
    check_eq("init_m_side", {m_AWREADY, m_WREADY, m_BVALID}, 0);
    check_eq("init_s_side", {s_AWVALID, s_WVALID, s_BREADY, wlast_err}, 0);
    drive();
    @(negedge ACLK);
    ARESETn = 1;

    // Single master, four beats, slave always ready.
    err_pulses = 0;
    start(0, 16'h0010, 3, 0);
    step();
    step();
    check_eq("m0_grant_latency", grant, 2'b01);
    wait_done(1, 0, 50, "m0_alone_done");
    step();
    check_eq("m0_grant_released", grant, 2'b00);
    check_eq("m0_no_wlast_err", err_pulses, 0);

    // Simultaneous requests from reset: m0, then m1, then m0 again.
    do_reset();
    done[0] = 0; done[1] = 0;
    order.delete();
    start(0, 16'h0100, 2, 0);
    start(1, 16'h0200, 1, 0);
    wait_done(1, 1, 100, "tie_pair_done");
    start(0, 16'h0300, 0, 0);
    start(1, 16'h0400, 0, 0);
    wait_done(2, 2, 100, "tie_second_done");
    check_eq("order_len", order.size(), 4);
    if (order.size() >= 3) begin
      check_eq("order_0", order[0], 0);
      check_eq("order_1", order[1], 1);
      check_eq("order_2", order[2], 0);
    end

    // m0 requests while m1 is mid-burst; no preemption.
    n = 0;
    start(1, 16'h0500, 7, 0);
    while (beat[1] < 3 && n < 100) begin step(); n++; end
    check_eq("m1_reached_beat3", beat[1], 3);
    start(0, 16'h0600, 2, 0);
    wait_done(2, 3, 100, "m1_long_done");
    check_eq("m0_waited", done[0], 2);
    wait_done(3, 3, 100, "m0_after_m1_done");

    // WLAST on the wrong beat pulses twice, count still rules.
    err_pulses = 0;
    start(0, 16'h0700, 1, 1);
    wait_done(4, 3, 100, "bad_wlast_done");
    step();
    check_eq("bad_wlast_pulses", err_pulses, 2);

    // Reset in the middle of a burst, then a fresh m1 request.
    n = 0;
    start(0, 16'h0800, 3, 0);
    while (beat[0] < 2 && n < 100) begin step(); n++; end
    check_eq("mid_burst_beat2", beat[0], 2);
    do_reset();
    done[0] = 0; done[1] = 0;
    start(1, 16'h0900, 0, 0);
    step();
    step();
    check_eq("post_reset_grant_m1", grant, 2'b10);
    wait_done(0, 1, 50, "post_reset_m1_done");

    // Maximum-length burst with a toggling WREADY.
    wtog = 1;
    start(0, 16'h0a00, 255, 0);
    wait_done(1, 1, 1200, "len255_done");
    wtog = 0;

    // Randomized traffic from both masters.
    rnd = 1;
    launched = 0;
    n = 0;
    target = done[0] + done[1] + 40;
    while ((done[0] + done[1]) < target && n < 20000) begin
      for (int i = 0; i < 2; i++) begin
        if (launched < 40 && !pend[i] && !wact[i] && !bact[i] && $urandom_range(0, 2) == 0) begin
          start(i, 16'($urandom), $urandom_range(0, 15), $urandom_range(0, 3) == 0);
          launched++;
        end
      end
      step();
      n++;
    end
    check_eq("random_done", done[0] + done[1], target);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
